// File: rtl/helios_stream_pkg.sv
// Shared types and word-format helpers for the Helios root readout stream.
// Root words use the golden-file layout {8'h00, z, x, y}.
package helios_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdrId,
        StHdrStat,
        StRoots
    } stream_state_e;

    localparam int unsigned Y_LSB           = 0;
    localparam int unsigned X_LSB           = 8;
    localparam int unsigned Z_LSB           = 16;
    localparam int unsigned STAT_CYCLE_BITS = 24;

    function automatic logic [31:0] pack_root_word(input logic [7:0] z,
                                                   input logic [7:0] x,
                                                   input logic [7:0] y);
        logic [31:0] word;
        word               = '0;
        word[Z_LSB +: 8]   = z;
        word[X_LSB +: 8]   = x;
        word[Y_LSB +: 8]   = y;
        return word;
    endfunction

endpackage

// File: rtl/helios_root_stream_out.sv
// Snapshots the decoder root vector on each result_valid rise and streams it out as
// one frame: round id, iteration/cycle stats, then one packed root word per PU.
module helios_root_stream_out
    import helios_stream_pkg::*;
#(
    parameter int CODE_DISTANCE_X         = 7,
    parameter int CODE_DISTANCE_Z         = 6,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    localparam int MEASUREMENT_ROUNDS     = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                            CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int PU_COUNT               = CODE_DISTANCE_X * CODE_DISTANCE_Z *
                                            MEASUREMENT_ROUNDS,
    localparam int PER_DIM_WIDTH          = $clog2(MEASUREMENT_ROUNDS),
    localparam int ADDRESS_WIDTH          = 3 * PER_DIM_WIDTH
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]  roots,
    input  logic                               result_valid,
    input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
    input  logic [31:0]                        cycle_counter,
    output logic [31:0]                        m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               m_last,
    output logic                               busy,
    output logic                               overrun,
    output logic [15:0]                        dropped_count
);

    localparam int IDX_WIDTH = $clog2(PU_COUNT);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PU_COUNT - 1);

    if (PER_DIM_WIDTH > 8) begin : g_dim_width_check
        $error("PER_DIM_WIDTH exceeds the 8-bit root word fields");
    end
    if (ITERATION_COUNTER_WIDTH > 8) begin : g_iter_width_check
        $error("ITERATION_COUNTER_WIDTH exceeds the 8-bit stat field");
    end

    stream_state_e                      state_q, state_d;
    logic [IDX_WIDTH-1:0]               idx_q, idx_d;
    logic [31:0]                        round_q, round_d;
    logic                               rv_q;
    logic [ADDRESS_WIDTH-1:0]           snap_q [PU_COUNT];
    logic [ITERATION_COUNTER_WIDTH-1:0] iter_q;
    logic [STAT_CYCLE_BITS-1:0]         cyc_q;
    logic                               overrun_q;
    logic [15:0]                        dropped_q;

    logic                               capture_evt;
    logic                               last_hs;
    logic                               accept;
    logic [ADDRESS_WIDTH-1:0]           slice;

    // Only the low cycle bits travel in the stat word.
    logic unused_cycle_hi;
    assign unused_cycle_hi = ^cycle_counter[31:STAT_CYCLE_BITS];

    assign capture_evt = result_valid & ~rv_q;
    assign last_hs     = (state_q == StRoots) && m_ready && (idx_q == LAST_IDX);
    // A new result can chain straight onto the handshake of the previous frame's last word.
    assign accept      = capture_evt && ((state_q == StIdle) || last_hs);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        round_d = round_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StHdrId;
            end
            StHdrId: begin
                if (m_ready) state_d = StHdrStat;
            end
            StHdrStat: begin
                if (m_ready) begin
                    state_d = StRoots;
                    idx_d   = '0;
                end
            end
            StRoots: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        round_d = round_q + 32'd1;
                        state_d = accept ? StHdrId : StIdle;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        slice   = snap_q[idx_q];
        m_valid = (state_q != StIdle);
        busy    = (state_q != StIdle);
        m_last  = (state_q == StRoots) && (idx_q == LAST_IDX);
        m_data  = '0;
        unique case (state_q)
            StIdle:    m_data = '0;
            StHdrId:   m_data = round_q;
            StHdrStat: m_data = {8'(iter_q), cyc_q};
            StRoots:   m_data = pack_root_word(
                           8'(slice[ADDRESS_WIDTH-1 -: PER_DIM_WIDTH]),
                           8'(slice[2*PER_DIM_WIDTH-1 -: PER_DIM_WIDTH]),
                           8'(slice[PER_DIM_WIDTH-1:0]));
            default:   m_data = '0;
        endcase
    end

    assign overrun       = overrun_q;
    assign dropped_count = dropped_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            round_q   <= '0;
            rv_q      <= 1'b0;
            iter_q    <= '0;
            cyc_q     <= '0;
            overrun_q <= 1'b0;
            dropped_q <= '0;
            for (int p = 0; p < PU_COUNT; p++) snap_q[p] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            round_q <= round_d;
            rv_q    <= result_valid;
            if (accept) begin
                iter_q <= iteration_counter;
                cyc_q  <= cycle_counter[STAT_CYCLE_BITS-1:0];
                for (int p = 0; p < PU_COUNT; p++) begin
                    snap_q[p] <= roots[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                end
            end
            if (capture_evt && !accept) begin
                overrun_q <= 1'b1;
                if (dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_helios_root_stream_out.sv
// Self-checking bench: table-driven frames, randomized frames and hand-written corner
// sequences, all checked against a behavioural frame model.
module tb_helios_root_stream_out;

    localparam int DX  = 3;
    localparam int DZ  = 2;
    localparam int ICW = 8;
    localparam int MR  = (DX > DZ) ? DX : DZ;
    localparam int PU  = DX * DZ * MR;
    localparam int PD  = $clog2(MR);
    localparam int AW  = 3 * PD;
    localparam int RW  = AW * PU;
    localparam int FW  = PU + 2;

    logic           clk;
    logic           reset;
    logic [RW-1:0]  roots;
    logic           result_valid;
    logic [ICW-1:0] iteration_counter;
    logic [31:0]    cycle_counter;
    logic [31:0]    m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic           busy;
    logic           overrun;
    logic [15:0]    dropped_count;

    helios_root_stream_out #(
        .CODE_DISTANCE_X        (DX),
        .CODE_DISTANCE_Z        (DZ),
        .ITERATION_COUNTER_WIDTH(ICW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .roots            (roots),
        .result_valid     (result_valid),
        .iteration_counter(iteration_counter),
        .cycle_counter    (cycle_counter),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last),
        .busy             (busy),
        .overrun          (overrun),
        .dropped_count    (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pat;
        logic [7:0]  iter;
        logic [31:0] cyc;
        logic [5:0]  pu5;
        logic [31:0] exp_w1;
        logic [31:0] exp_w7;
    } vec_t;

    vec_t          vecs [3];
    logic [32:0]   rx_q [$];
    logic [32:0]   exp_q [$];
    int            checks;
    int            failures;
    logic [RW-1:0] inj_roots;
    logic [7:0]    inj_iter;
    logic [31:0]   inj_cyc;
    logic          post_valid;
    logic [31:0]   post_data;
    logic          st_prev;
    logic [31:0]   st_data;
    logic          st_last;
    int unsigned   round;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_roots();
        logic [RW-1:0] r;
        r = '0;
        for (int b = 0; b < (RW + 31) / 32; b++) r = (r << 32) | RW'($urandom);
        return r;
    endfunction

    // Expected frame from first principles: header words, then roots in k, i, j order.
    function automatic void model_frame(input int unsigned rid, input logic [RW-1:0] r,
                                        input logic [7:0] it, input logic [31:0] cy);
        int unsigned   base, pu_i, slice, z, x, y, w, n;
        logic [RW-1:0] sh;
        base = 1 << PD;
        exp_q.push_back({1'b0, 32'(rid)});
        w = 32'(it) * 32'h0100_0000 + (cy % 32'h0100_0000);
        exp_q.push_back({1'b0, 32'(w)});
        n = 0;
        for (int k = 0; k < MR; k++) begin
            for (int i = 0; i < DX; i++) begin
                for (int j = 0; j < DZ; j++) begin
                    pu_i  = i * DZ + j + k * DZ * DX;
                    sh    = r >> (pu_i * AW);
                    slice = 32'(sh[AW-1:0]);
                    z     = slice / (base * base);
                    x     = (slice / base) % base;
                    y     = slice % base;
                    w     = z * 65536 + x * 256 + y;
                    exp_q.push_back({(n == PU - 1), 32'(w)});
                    n++;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && m_valid && m_ready) rx_q.push_back({m_last, m_data});
    end

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            st_prev <= 1'b0;
        end else begin
            if (st_prev) check("stall_hold", {m_valid, m_last, m_data}, {1'b1, st_last, st_data});
            st_prev <= m_valid && !m_ready;
            st_data <= m_data;
            st_last <= m_last;
        end
    end

    task automatic run_frames(input logic [3:0] pat, input int inject_at, input int hold,
                              input int n_words);
        int c;
        bit injected;
        bit inj_prev;
        rx_q.delete();
        injected = 0;
        inj_prev = 0;
        @(posedge clk); #1;
        check("idle_before_capture", m_valid, 1'b0);
        result_valid = 1'b1;
        m_ready      = 1'b0;
        @(posedge clk); #1;
        check("capture_latency", m_valid, 1'b1);
        roots = rand_roots();
        c = 0;
        while ((rx_q.size() < n_words || c + 1 < hold) && c < 400) begin
            if (inj_prev) begin
                post_valid = m_valid;
                post_data  = m_data;
                inj_prev   = 0;
            end
            if (rx_q.size() < n_words) check("busy_in_frame", busy, 1'b1);
            m_ready      = pat[3 - (c % 4)];
            result_valid = (c + 1 < hold);
            if (!injected && inject_at >= 0 && rx_q.size() == inject_at) begin
                result_valid      = 1'b1;
                roots             = inj_roots;
                iteration_counter = inj_iter;
                cycle_counter     = inj_cyc;
                injected          = 1;
                inj_prev          = 1;
            end
            c++;
            @(posedge clk); #1;
        end
        result_valid = 1'b0;
        m_ready      = 1'b1;
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic new_inputs();
        roots             = rand_roots();
        iteration_counter = 8'($urandom);
        cycle_counter     = $urandom;
    endtask

    initial begin
        vecs[0] = '{4'b1111, 8'd4,    32'd37,        6'b01_10_01, 32'h0400_0025, 32'h0001_0201};
        vecs[1] = '{4'b1001, 8'hAB,   32'hFF12_3456, 6'b11_00_10, 32'hAB12_3456, 32'h0003_0002};
        vecs[2] = '{4'b0110, 8'h00,   32'h00FF_FFFF, 6'b00_11_11, 32'h00FF_FFFF, 32'h0000_0303};

        checks = 0;
        failures = 0;
        reset = 1'b0;
        result_valid = 1'b0;
        m_ready = 1'b1;
        roots = '0;
        iteration_counter = '0;
        cycle_counter = '0;
        inj_roots = '0;
        inj_iter = '0;
        inj_cyc = '0;
        post_valid = 1'b0;
        post_data = '0;

        #12;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_dropped", dropped_count, 16'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        round = 0;
        for (int v = 0; v < 3; v++) begin
            roots = rand_roots();
            roots[5*AW +: AW] = vecs[v].pu5;
            iteration_counter = vecs[v].iter;
            cycle_counter = vecs[v].cyc;
            model_frame(round, roots, iteration_counter, cycle_counter);
            run_frames(vecs[v].pat, -1, 1, FW);
            if (rx_q.size() >= FW) begin
                check($sformatf("vec%0d_w1", v), rx_q[1][31:0], vecs[v].exp_w1);
                check($sformatf("vec%0d_w7", v), rx_q[7][31:0], vecs[v].exp_w7);
            end
            compare_rx($sformatf("vec%0d", v));
            round++;
        end

        for (int r = 0; r < 3; r++) begin
            new_inputs();
            model_frame(round, roots, iteration_counter, cycle_counter);
            run_frames(4'($urandom_range(1, 15)), -1, 1, FW);
            compare_rx($sformatf("rand%0d", r));
            round++;
        end

        new_inputs();
        inj_roots = rand_roots();
        inj_iter = 8'($urandom);
        inj_cyc = $urandom;
        model_frame(round, roots, iteration_counter, cycle_counter);
        model_frame(round + 1, inj_roots, inj_iter, inj_cyc);
        run_frames(4'hF, FW - 1, 1, 2 * FW);
        compare_rx("b2b");
        check("b2b_no_gap_valid", post_valid, 1'b1);
        check("b2b_next_round", post_data, 32'(round + 1));
        check("b2b_overrun", overrun, 1'b0);
        round += 2;

        new_inputs();
        inj_roots = rand_roots();
        inj_iter = 8'($urandom);
        inj_cyc = $urandom;
        model_frame(round, roots, iteration_counter, cycle_counter);
        run_frames(4'hF, 10, 1, FW);
        compare_rx("ovr");
        repeat (30) @(posedge clk);
        #1;
        check("ovr_no_second_frame", 64'(rx_q.size()), 64'(FW));
        check("ovr_busy_idle", busy, 1'b0);
        check("ovr_overrun", overrun, 1'b1);
        check("ovr_dropped", dropped_count, 16'd1);
        round++;

        new_inputs();
        rx_q.delete();
        @(posedge clk); #1;
        result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 100 && rx_q.size() < 8; c++) begin
            @(posedge clk); #1;
        end
        check("midrst_reached_w8", 64'(rx_q.size()), 64'd8);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_m_data", m_data, 32'h0);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_dropped", dropped_count, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        round = 0;
        new_inputs();
        model_frame(round, roots, iteration_counter, cycle_counter);
        run_frames(4'hF, -1, 1, FW);
        if (rx_q.size() >= 1) check("midrst_restart_w0", rx_q[0][31:0], 32'h0);
        compare_rx("midrst");
        round++;

        new_inputs();
        model_frame(round, roots, iteration_counter, cycle_counter);
        run_frames(4'hF, -1, 50, FW);
        compare_rx("level");
        repeat (20) @(posedge clk);
        #1;
        check("level_one_frame", 64'(rx_q.size()), 64'(FW));
        check("level_dropped", dropped_count, 16'h0);
        check("level_busy_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
